// File: rtl/qsfp_link_seq.sv
// qsfp_link_seq: bring-up and supervision sequencer for the QSFP transceiver block.
// Holds the transceivers in reset for a power-on interval, releases reset,
// waits for reset-done and stable lane lock, then reports link up. Timeouts and
// loss of lock re-sequence; a bounded run of consecutive failures parks in FAIL.
//
// Ports:
//   sys_clk_i    system clock
//   sys_rst_i    synchronous active-high reset
//   enable_i     level; high requests bring-up, low forces IDLE
//   resetdone_i  transceiver reset-done (asynchronous, 2-flop synchronised)
//   lane_lock_i  per-lane lock (asynchronous, 2-flop synchronised per bit)
//   gt_reset_o   registered active-high transceiver reset
//   link_up_o    registered, high only in UP
//   lanes_up_o   registered synchronised lane lock & LANE_MASK
//   retry_cnt_o  total re-sequence count, saturating at 255
//   fail_o       high only in FAIL
//   state_o      state code (IDLE=0 HOLD=1 WAIT_DONE=2 WAIT_LOCK=3 UP=4 FAIL=5)
module qsfp_link_seq #(
  parameter int unsigned          NUM_LANES    = 8,
  parameter logic [NUM_LANES-1:0] LANE_MASK    = {NUM_LANES{1'b1}},
  parameter int unsigned          POR_CYCLES   = 1024,
  parameter int unsigned          DONE_TIMEOUT = 65536,
  parameter int unsigned          LOCK_STABLE  = 4096,
  parameter int unsigned          MAX_RETRIES  = 3
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic                 enable_i,
  input  logic                 resetdone_i,
  input  logic [NUM_LANES-1:0] lane_lock_i,
  output logic                 gt_reset_o,
  output logic                 link_up_o,
  output logic [NUM_LANES-1:0] lanes_up_o,
  output logic [7:0]           retry_cnt_o,
  output logic                 fail_o,
  output logic [2:0]           state_o
);

  localparam int unsigned MAX_A = (POR_CYCLES > DONE_TIMEOUT) ? POR_CYCLES : DONE_TIMEOUT;
  localparam int unsigned MAX_P = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
  localparam int unsigned TW    = $clog2(MAX_P) + 1;
  localparam int unsigned CW    = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOLD      = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_UP        = 3'd4,
    S_FAIL      = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [TW-1:0]        stab_q, stab_d;
  logic [CW-1:0]        cf_q, cf_d;
  logic [7:0]           retry_q, retry_d;

  logic                 rd_m_q, rd_s_q;
  logic [NUM_LANES-1:0] lk_m_q, lk_s_q;

  logic                 gt_reset_q, link_up_q, fail_q;
  logic [NUM_LANES-1:0] lanes_up_q;

  logic                 masked_ok;
  logic                 link_ok;
  logic                 lock_done;
  logic                 fail_evt;

  assign masked_ok = ((lk_s_q & LANE_MASK) == LANE_MASK);
  assign link_ok   = masked_ok && rd_s_q;
  // Stability completes on the cycle the counter would reach LOCK_STABLE.
  assign lock_done = link_ok && (stab_q == TW'(LOCK_STABLE - 1));

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    stab_d   = stab_q;
    cf_d     = cf_q;
    retry_d  = retry_q;
    fail_evt = 1'b0;

    if (!enable_i) begin
      state_d = S_IDLE;
      timer_d = '0;
      stab_d  = '0;
      cf_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_HOLD;
          timer_d = TW'(POR_CYCLES - 1);
        end
        S_HOLD: begin
          if (timer_q == '0) begin
            state_d = S_WAIT_DONE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (rd_s_q) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
            stab_d  = '0;
          end else if (timer_q == TW'(DONE_TIMEOUT - 1)) begin
            fail_evt = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_WAIT_LOCK: begin
          // Lock completion is tested before the timeout so it wins a tie.
          if (!rd_s_q) begin
            fail_evt = 1'b1;
          end else if (lock_done) begin
            state_d = S_UP;
            cf_d    = '0;
          end else if (timer_q == TW'(DONE_TIMEOUT - 1)) begin
            fail_evt = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
            stab_d  = masked_ok ? (stab_q + TW'(1)) : '0;
          end
        end
        S_UP: begin
          if (!link_ok) fail_evt = 1'b1;
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (fail_evt) begin
        if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        cf_d = cf_q + CW'(1);
        if (cf_d == CW'(MAX_RETRIES)) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_HOLD;
          timer_d = TW'(POR_CYCLES - 1);
          stab_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      stab_q     <= '0;
      cf_q       <= '0;
      retry_q    <= '0;
      rd_m_q     <= 1'b0;
      rd_s_q     <= 1'b0;
      lk_m_q     <= '0;
      lk_s_q     <= '0;
      gt_reset_q <= 1'b1;
      link_up_q  <= 1'b0;
      fail_q     <= 1'b0;
      lanes_up_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      stab_q     <= stab_d;
      cf_q       <= cf_d;
      retry_q    <= retry_d;
      rd_m_q     <= resetdone_i;
      rd_s_q     <= rd_m_q;
      lk_m_q     <= lane_lock_i;
      lk_s_q     <= lk_m_q;
      // Registered off the next state so they move together with state_o.
      gt_reset_q <= (state_d == S_IDLE) || (state_d == S_HOLD) || (state_d == S_FAIL);
      link_up_q  <= (state_d == S_UP);
      fail_q     <= (state_d == S_FAIL);
      lanes_up_q <= lk_s_q & LANE_MASK;
    end
  end

  assign gt_reset_o  = gt_reset_q;
  assign link_up_o   = link_up_q;
  assign fail_o      = fail_q;
  assign lanes_up_o  = lanes_up_q;
  assign retry_cnt_o = retry_q;
  assign state_o     = state_q;

endmodule
